// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command FIFO and one-shot driver for an external combinational ALU
//
// Buffers {a, b, s, chain} commands in a DEPTH-entry FIFO. Each command is
// presented to the ALU for exactly one enabled cycle. Z is captured and then
// held behind a valid/ready result handshake.
//
// Optional feature macro: ALU_SEQ_CHAIN_EN
//   When defined, a command popped with chain=1 takes operand A from the
//   current res_z register instead of its stored cmd_a.
//   When undefined, cmd_chain is ignored.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; payload cmd_a, cmd_b, cmd_s, cmd_chain
//   alu_a/alu_b/alu_s       operands and select driven to the ALU
//   alu_en                  ALU enable, high only in the DRIVE state
//   alu_z                   ALU result
//   res_valid/res_ready     result handshake; payload res_z
//   count                   FIFO occupancy
//   busy                    FSM not idle or FIFO non-empty
module alu_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_a,
  input  logic [WIDTH-1:0]           cmd_b,
  input  logic [SEL_W-1:0]           cmd_s,
  input  logic                       cmd_chain,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [SEL_W-1:0]           alu_s,
  output logic                       alu_en,
  input  logic [WIDTH-1:0]           alu_z,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_z,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic             ready_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [SEL_W-1:0] mem_s [DEPTH];

  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_a;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  // Gating on count alone (not on a same-cycle pop) keeps a full FIFO closed.
  assign cmd_ready  = ready_q && !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  // Pop from IDLE, or from HOLD when the current result is handed off.
  assign pop        = !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_HOLD) && res_ready));
  assign count      = count_q;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

`ifdef ALU_SEQ_CHAIN_EN
  logic mem_c [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_c[wr_ptr] <= cmd_chain;
    end
  end

  // res_z still holds the previous result here, including during a back-to-back pop from HOLD.
  assign head_a = mem_c[rd_ptr] ? res_z : mem_a[rd_ptr];
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
  assign head_a       = mem_a[rd_ptr];
`endif

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= cmd_a;
      mem_b[wr_ptr] <= cmd_b;
      mem_s[wr_ptr] <= cmd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ready_q   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      alu_en    <= 1'b0;
      res_valid <= 1'b0;
      res_z     <= '0;
    end else begin
      ready_q <= 1'b1;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end

      if (pop) begin
        alu_a <= head_a;
        alu_b <= mem_b[rd_ptr];
        alu_s <= mem_s[rd_ptr];
      end

      case (state)
        ST_IDLE: begin
          if (pop) begin
            alu_en <= 1'b1;
            state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          alu_en    <= 1'b0;
          res_z     <= alu_z;
          res_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              alu_en <= 1'b1;
              state  <= ST_DRIVE;
            end else begin
              state  <= ST_IDLE;
            end
          end
        end
        default: begin
          alu_en    <= 1'b0;
          res_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with an adder ALU stub
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_s;
  logic       cmd_chain;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic       alu_en;
  logic [3:0] alu_z;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_z;
  logic [2:0] count;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign alu_z = alu_en ? 4'(alu_a + alu_b) : 4'd0;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_s     (cmd_s),
    .cmd_chain (cmd_chain),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_en    (alu_en),
    .alu_z     (alu_z),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_z     (res_z),
    .count     (count),
    .busy      (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: results are produced in command order; a chained
  // command adds b to the previous result (0 after reset).
  typedef struct {
    int a;
    int b;
    bit chain;
  } cmd_t;

  cmd_t model_q[$];
  int   prev_res = 0;
  int   cyc = 0;
  int   en_cyc[$];
  bit   en_prev = 1'b0;
  bit   hold_v = 1'b0;
  int   hold_z = 0;

  always @(posedge clk) cyc++;

  always @(negedge rst_n) begin
    model_q.delete();
    prev_res = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        cmd_t c;
        c.a = int'(cmd_a);
        c.b = int'(cmd_b);
        c.chain = cmd_chain;
        model_q.push_back(c);
      end
      if (res_valid && res_ready) begin
        if (model_q.size() == 0) begin
          check("res_spurious", 1, 0);
        end else begin
          cmd_t c;
          int a_eff;
          int exp;
          c = model_q.pop_front();
          a_eff = (CHAIN && c.chain) ? prev_res : c.a;
          exp = (a_eff + c.b) % 16;
          check("res_z_model", int'(res_z), exp);
          prev_res = exp;
        end
      end
      if (hold_v) begin
        check("res_valid_hold", int'(res_valid), 1);
        check("res_z_stable", int'(res_z), hold_z);
      end
      hold_v = res_valid && !res_ready;
      hold_z = int'(res_z);
      if (alu_en) begin
        check("alu_en_pulse", int'(en_prev), 0);
        en_cyc.push_back(cyc);
      end
      en_prev = alu_en;
    end else begin
      hold_v = 1'b0;
      en_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int s, input bit ch);
    bit acc;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_a = 4'(a);
    cmd_b = 4'(b);
    cmd_s = 3'(s);
    cmd_chain = ch;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_result(input string tag, input int exp);
    int n;
    n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, int'(res_valid), 1);
    check(tag, int'(res_z), exp);
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int hs[$];
    bit acc;

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_s = '0;
    cmd_chain = 1'b0;
    res_ready = 1'b0;
    #1;
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_b", int'(alu_b), 0);
    check("rst_alu_s", int'(alu_s), 0);
    check("rst_alu_en", int'(alu_en), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_z", int'(res_z), 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    #1;
    check("rel_cmd_ready_0", int'(cmd_ready), 0);
    tick();
    check("rel_cmd_ready_1", int'(cmd_ready), 1);

    // Single command 9+5
    res_ready = 1'b1;
    send(9, 5, 0, 1'b0);
    check("single_count", int'(count), 1);
    check("single_en_e0", int'(alu_en), 0);
    tick();
    check("single_en_e1", int'(alu_en), 1);
    check("single_alu_s", int'(alu_s), 0);
    check("single_alu_a", int'(alu_a), 9);
    check("single_valid_e1", int'(res_valid), 0);
    tick();
    check("single_en_e2", int'(alu_en), 0);
    check("single_valid_e2", int'(res_valid), 1);
    check("single_res_z", int'(res_z), 14);
    tick();
    check("single_valid_done", int'(res_valid), 0);
    check("single_busy", int'(busy), 0);

    // Backpressure and full FIFO
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(i, 1, 0, 1'b0);
    check("full_count", int'(count), 4);
    check("full_cmd_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_a = 4'd6;
    cmd_b = 4'd1;
    cmd_chain = 1'b0;
    tick();
    tick();
    tick();
    check("full_stall_count", int'(count), 4);
    check("full_res_valid", int'(res_valid), 1);
    check("full_res_z", int'(res_z), 2);
    res_ready = 1'b1;
    for (int c = 0; c < 60 && hs.size() < 6; c++) begin
      if (res_valid && res_ready) hs.push_back(c);
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) cmd_valid = 1'b0;
    end
    check("drain_count", hs.size(), 6);
    if (hs.size() == 6) begin
      for (int i = 1; i < 5; i++) check("drain_spacing", hs[i] - hs[i-1], 2);
    end
    wait_idle();

    // Back-to-back with res_ready held
    en_cyc.delete();
    for (int i = 0; i < 3; i++) send(2 * i + 1, 3, i, 1'b0);
    wait_idle();
    check("b2b_pulses", en_cyc.size(), 3);
    if (en_cyc.size() == 3) begin
      check("b2b_gap0", en_cyc[1] - en_cyc[0], 2);
      check("b2b_gap1", en_cyc[2] - en_cyc[1], 2);
    end

    // Chain
    send(3, 4, 0, 1'b0);
    wait_result("chain_first", 7);
    send(0, 5, 0, 1'b1);
    wait_result("chain_second", CHAIN ? 12 : 5);
    wait_idle();

    // Reset during DRIVE with two commands queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(i + 2, 2, 1, 1'b0);
    tick();
    check("mid_pre_count", int'(count), 3);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("mid_in_drive", int'(alu_en), 1);
    check("mid_queued", int'(count), 2);
    rst_n = 1'b0;
    #1;
    check("mid_res_valid", int'(res_valid), 0);
    check("mid_count", int'(count), 0);
    check("mid_alu_en", int'(alu_en), 0);
    check("mid_cmd_ready", int'(cmd_ready), 0);
    tick();
    #2 rst_n = 1'b1;
    res_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid || alu_en) acc = 1'b1;
      tick();
    end
    check("mid_no_result", int'(acc), 0);
    check("mid_busy", int'(busy), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a = 4'($urandom);
      cmd_b = 4'($urandom);
      cmd_s = 3'($urandom);
      cmd_chain = 1'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_count_range", int'(count <= 3'd4), 1);
      check("rnd_cmd_ready", int'(cmd_ready), int'(count != 3'd4));
      if (count != 3'd0) check("rnd_busy", int'(busy), 1);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle();
    tick();
    check("rnd_model_empty", model_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream feeder for the combinational `ALU` (operands A, B, select S, enable en; result Z).
- Buffers operation commands in a small FIFO.
- Presents each command to the ALU for exactly one enabled cycle and captures Z.
- Holds the captured result behind a valid/ready output handshake.
- Sits between the command source and the ALU in the datapath; the ALU itself is instantiated outside this block.

## Interface
Parameters:
- `WIDTH`, 4: operand/result width
- `SEL_W`, 3: ALU select width
- `DEPTH`, 4: command FIFO depth; power of 2, ≥2

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  FIFO can accept
- `cmd_a`  in  WIDTH  operand A
- `cmd_b`  in  WIDTH  operand B
- `cmd_s`  in  SEL_W  ALU select
- `cmd_chain`  in  1  use last result as A (macro-dependent)
- `alu_a`  out  WIDTH  to ALU A
- `alu_b`  out  WIDTH  to ALU B
- `alu_s`  out  SEL_W  to ALU S
- `alu_en`  out  1  to ALU en
- `alu_z`  in  WIDTH  from ALU Z
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts
- `res_z`  out  WIDTH  captured result
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `busy`  out  1  FSM not IDLE or FIFO non-empty

## Operation
- Accept: `cmd_valid && cmd_ready` at an edge writes {a,b,s,chain} to the FIFO tail.
- `cmd_ready` = `ready_q && (count != DEPTH)`. `ready_q` resets to 0 and sets to 1 on the first edge after `rst_n` rises. Full FIFO blocks a push even if a pop occurs in the same cycle.
- Push and pop in the same cycle leave `count` unchanged. Pointers wrap modulo `DEPTH`.
- FSM states:
  - IDLE: if FIFO non-empty, pop head, load `alu_a/alu_b/alu_s`, go to DRIVE.
  - DRIVE: `alu_en`=1. At the end of the cycle, register `alu_z` into `res_z`, set `res_valid`, go to HOLD.
  - HOLD: `res_valid`=1, `res_z` stable. On `res_ready`:
    - if FIFO non-empty, pop and load operands, go to DRIVE (back-to-back);
    - else clear `res_valid`, go to IDLE.
- `alu_en` is 1 only in DRIVE. `alu_a/b/s` hold their last loaded values in the other states.
- Arithmetic: none internal. Z is captured verbatim at `WIDTH` bits.

## Timing
- Reset values:
  - `cmd_ready`=0, `alu_a`=0, `alu_b`=0, `alu_s`=0, `alu_en`=0
  - `res_valid`=0, `res_z`=0, `count`=0, `busy`=0
  - FSM in IDLE, FIFO empty
- Latency:
  - command accepted at edge E0 → popped at E1 (DRIVE during cycle E1–E2);
  - `res_valid`=1 after E2, i.e. 2 edges after acceptance into an empty, idle block.
- Throughput: one result per 2 cycles with `res_ready` held 1.
- `res_valid` never drops without a handshake. `res_z` is constant while `res_valid && !res_ready`.
- Reset mid-operation: asynchronously returns all state to reset values. In-flight and queued commands are discarded, and no result is produced for them.

## Configuration
- `ALU_SEQ_CHAIN_EN` defined: a command popped with `chain`=1 loads `alu_a` from the current `res_z` register instead of its stored `cmd_a`; `res_z` is 0 after reset.
- Not defined: `cmd_chain` is ignored; `alu_a` is always the stored `cmd_a`.

## Test plan
The bench stubs the ALU as `alu_z` = `alu_en` ? (`alu_a`+`alu_b`) mod 16 : 0, with default parameters.

- Reset: `rst_n`=0 → all outputs 0. Release → `cmd_ready`=1 after one edge.
- Single command: a=9, b=5, s=0, `res_ready`=1.
  - `alu_en` high for exactly one cycle, `alu_s`=0.
  - `res_valid` two edges after accept, `res_z`=14 (0xE).
  - Returns to IDLE, `busy`=0.
- Backpressure / full: `res_ready`=0, offer 6 commands (a=1..6, b=1).
  - First pops, `res_z`=2 held stable.
  - Next 4 fill the FIFO: `count`=4, `cmd_ready`=0, 6th stalled.
  - Raise `res_ready` → results 2,3,4,5,6 at 2-cycle spacing, then 7 after the 6th is accepted.
- Back-to-back: 3 queued commands with `res_ready`=1 → `alu_en` pulses on alternate cycles with no IDLE cycle between results.
- Chain: (a=3, b=4) then (a=0, b=5, chain=1).
  - With `ALU_SEQ_CHAIN_EN`: results 7, then 12.
  - Without it: 7, then 5.
- Reset mid-op: assert `rst_n`=0 during DRIVE with 2 queued → `res_valid`=0, `count`=0 immediately. No result appears after release.
